instr_mem_responder: RTL and testbench

Instruction-memory responder for the single-cycle/multi-cycle MIPS datapath. It answers fetch requests carrying the byte address produced by the program counter and returns the 32-bit instruction word after a fixed, parameterised latency. It has a load port for preloading the program image and flags misaligned or out-of-range fetches. It sits between the PC register and the instruction decode stage.

---
 rtl/instr_mem_responder_if.sv | 17 +
 rtl/instr_mem_responder.sv | 71 +++++++
 tb/tb_instr_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: fetch, response and load-port signals of the instruction memory
interface instr_mem_responder_if #(parameter int AW = 8);
  logic          reqValid;
  logic [31:0]   reqAddr;
  logic          reqReady;
  logic          respValid;
  logic [31:0]   respData;
  logic          respError;
  logic          busy;
  logic          loadEn;
  logic [AW-1:0] loadAddr;
  logic [31:0]   loadData;
  modport master (output reqValid, reqAddr, loadEn, loadAddr, loadData,
                  input reqReady, respValid, respData, respError, busy);
  modport slave  (input reqValid, reqAddr, loadEn, loadAddr, loadData,
                  output reqReady, respValid, respData, respError, busy);
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency instruction fetch responder with preload port and fault flag
module instr_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic CLK,
  input logic RSTn,
  instr_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        pend_err_q, pend_err_d, resp_err_q, resp_err_d;
  logic [31:0] pend_data_q, pend_data_d, resp_data_q, resp_data_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [32:0] off;
  logic        err, accept;
  // 33-bit offset: bit 32 set means the address lies below the base
  assign off            = {1'b0, bus.reqAddr} - {1'b0, BASE_ADDR};
  assign err            = (|off[1:0]) || off[32] || (|off[31:AW+2]);
  assign bus.reqReady   = RSTn && (state_q != WAIT);
  assign accept         = bus.reqValid && bus.reqReady;
  assign bus.respValid  = state_q == RESP;
  assign bus.busy       = state_q != IDLE;
  assign bus.respData   = resp_data_q;
  assign bus.respError  = resp_err_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_err_d  = pend_err_q;
    pend_data_d = pend_data_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    if (state_q == WAIT) begin
      state_d     = cnt_q == 2'd0 ? RESP : WAIT;
      cnt_d       = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
      resp_err_d  = cnt_q == 2'd0 ? pend_err_q : resp_err_q;
      resp_data_d = cnt_q == 2'd0 ? pend_data_q : resp_data_q;
    end
    if (state_q == RESP) state_d = IDLE;
    // the read happens against pre-edge memory, so a colliding load is seen by the next fetch only
    if (accept) begin
      state_d     = WAIT;
      cnt_d       = 2'(LATENCY - 1);
      pend_err_d  = err;
      pend_data_d = err ? 32'd0 : mem[off[AW+1:2]];
    end
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      pend_err_q  <= 1'b0;
      pend_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
      resp_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_err_q  <= pend_err_d;
      pend_data_q <= pend_data_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (bus.loadEn) mem[bus.loadAddr] <= bus.loadData;
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for the instruction memory responder
module tb_instr_mem_responder;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  logic [32:0] exp_q [$];
  int rcyc [$];
  instr_mem_responder_if #(.AW(8)) ifa ();
  instr_mem_responder_if #(.AW(8)) ifb ();
  instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(ifa.slave));
  instr_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0040_0000)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .bus(ifb.slave));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (ifa.respValid) begin
      logic [32:0] e;
      total++;
      rcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got err=%0b data=%h want no response", ifa.respError, ifa.respData);
      end else begin
        e = exp_q.pop_front();
        if ({ifa.respError, ifa.respData} !== e) begin
          bad++;
          $display("FAIL resp_data got err=%0b data=%h want err=%0b data=%h",
                   ifa.respError, ifa.respData, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge CLK);
    ifa.loadEn = 1'b1; ifa.loadAddr = a; ifa.loadData = d;
    @(negedge CLK);
    ifa.loadEn = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin @(negedge CLK); n++; end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
  endtask
  task automatic fetch(input logic [31:0] a, input logic e, input logic [31:0] d);
    @(negedge CLK);
    ifa.reqValid = 1'b1; ifa.reqAddr = a;
    exp_q.push_back({e, d});
    @(posedge CLK); #1;
    ifa.reqValid = 1'b0;
    drain();
  endtask
  task automatic fetch_b(input logic [31:0] a, input logic e, input logic [31:0] d);
    int n = 0;
    @(negedge CLK);
    ifb.reqValid = 1'b1; ifb.reqAddr = a;
    @(posedge CLK); #1;
    ifb.reqValid = 1'b0;
    while (!ifb.respValid && n < 10) begin @(negedge CLK); n++; end
    total++;
    if (!ifb.respValid || {ifb.respError, ifb.respData} !== {e, d}) begin
      bad++;
      $display("FAIL base_fetch addr=%h got valid=%0b err=%0b data=%h want err=%0b data=%h",
               a, ifb.respValid, ifb.respError, ifb.respData, e, d);
    end
  endtask
  task automatic test_reset();
    ifa.reqValid = 1'b1; ifa.reqAddr = 32'h0; ifa.loadEn = 1'b0; ifa.loadAddr = '0; ifa.loadData = '0;
    ifb.reqValid = 1'b0; ifb.reqAddr = 32'h0; ifb.loadEn = 1'b0; ifb.loadAddr = '0; ifb.loadData = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({ifa.reqReady, ifa.respValid, ifa.busy, ifa.respError, ifa.respData} !== 36'h0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b busy=%0b err=%0b data=%h want all 0",
               ifa.reqReady, ifa.respValid, ifa.busy, ifa.respError, ifa.respData);
    end
    ifa.reqValid = 1'b0;
    RSTn = 1'b1;
    #1;
    total++;
    if (ifa.reqReady !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %0b want 1", ifa.reqReady); end
  endtask
  task automatic test_aligned();
    load(8'd3, 32'h2008_0005);
    @(negedge CLK);
    ifa.reqValid = 1'b1; ifa.reqAddr = 32'h0000_000C;
    exp_q.push_back({1'b0, 32'h2008_0005});
    @(posedge CLK); #1;
    ifa.reqValid = 1'b0;
    total++;
    if ({ifa.busy, ifa.reqReady, ifa.respValid} !== 3'b100) begin
      bad++; $display("FAIL aligned_k got busy/rdy/vld=%b want 100", {ifa.busy, ifa.reqReady, ifa.respValid});
    end
    @(posedge CLK); #1;
    total++;
    if ({ifa.busy, ifa.respValid} !== 2'b10) begin
      bad++; $display("FAIL aligned_k1 got busy/vld=%b want 10", {ifa.busy, ifa.respValid});
    end
    @(posedge CLK); #1;
    total++;
    if ({ifa.busy, ifa.respValid} !== 2'b11) begin
      bad++; $display("FAIL aligned_k2 got busy/vld=%b want 11", {ifa.busy, ifa.respValid});
    end
    @(posedge CLK); #1;
    total++;
    if ({ifa.busy, ifa.respValid, ifa.respData} !== {2'b00, 32'h2008_0005}) begin
      bad++; $display("FAIL aligned_k3 got busy/vld=%b data=%h want 00 data=20080005",
                      {ifa.busy, ifa.respValid}, ifa.respData);
    end
    drain();
  endtask
  task automatic test_errors();
    load(8'd255, 32'hDEAD_BEEF);
    fetch(32'h0000_0006, 1'b1, 32'h0);
    fetch(32'h0000_0400, 1'b1, 32'h0);
    fetch(32'h0000_03FC, 1'b0, 32'hDEAD_BEEF);
    fetch(32'hFFFF_FFFC, 1'b1, 32'h0);
    @(negedge CLK);
    ifb.loadEn = 1'b1; ifb.loadAddr = 8'd2; ifb.loadData = 32'h1234_5678;
    @(negedge CLK);
    ifb.loadEn = 1'b0;
    fetch_b(32'h0000_0000, 1'b1, 32'h0);
    fetch_b(32'h003F_FFFC, 1'b1, 32'h0);
    fetch_b(32'h0040_0008, 1'b0, 32'h1234_5678);
  endtask
  task automatic test_back_to_back();
    int k0 = 0;
    load(8'd0, 32'h1111_0000);
    load(8'd1, 32'h2222_0001);
    load(8'd2, 32'h3333_0002);
    rcyc.delete();
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      @(negedge CLK);
      ifa.reqValid = 1'b1; ifa.reqAddr = 32'(4 * i);
      exp_q.push_back({1'b0, (i == 0) ? 32'h1111_0000 : (i == 1) ? 32'h2222_0001 : 32'h3333_0002});
      if (i > 0) begin
        total++;
        if (ifa.reqReady !== 1'b0) begin bad++; $display("FAIL b2b_wait_ready got %0b want 0", ifa.reqReady); end
      end
      while (!ifa.reqReady && n < 10) begin @(negedge CLK); n++; end
      @(posedge CLK); #1;
      if (i == 0) k0 = cyc;
    end
    ifa.reqValid = 1'b0;
    drain();
    total++;
    if (rcyc.size() != 3 || rcyc[0] != k0 + 2 || rcyc[1] != k0 + 5 || rcyc[2] != k0 + 8) begin
      bad++;
      $display("FAIL b2b_timing got n=%0d first=%0d want n=3 at %0d,%0d,%0d",
               rcyc.size(), (rcyc.size() > 0) ? rcyc[0] - k0 : -1, 2, 5, 8);
    end
  endtask
  task automatic test_collision();
    load(8'd5, 32'hAAAA_AAAA);
    load(8'd6, 32'h6666_6666);
    @(negedge CLK);
    ifa.reqValid = 1'b1; ifa.reqAddr = 32'h0000_0014;
    ifa.loadEn = 1'b1; ifa.loadAddr = 8'd5; ifa.loadData = 32'h5555_5555;
    exp_q.push_back({1'b0, 32'hAAAA_AAAA});
    @(posedge CLK); #1;
    ifa.reqValid = 1'b0; ifa.loadEn = 1'b0;
    drain();
    fetch(32'h0000_0014, 1'b0, 32'h5555_5555);
    @(negedge CLK);
    ifa.reqValid = 1'b1; ifa.reqAddr = 32'h0000_0018;
    exp_q.push_back({1'b0, 32'h6666_6666});
    @(posedge CLK); #1;
    ifa.reqValid = 1'b0;
    ifa.reqAddr = 32'h0000_0014;
    ifa.loadEn = 1'b1; ifa.loadAddr = 8'd6; ifa.loadData = 32'h7777_7777;
    @(posedge CLK); #1;
    ifa.loadEn = 1'b0;
    drain();
    fetch(32'h0000_0018, 1'b0, 32'h7777_7777);
  endtask
  task automatic test_reset_mid();
    int n0;
    @(negedge CLK);
    ifa.reqValid = 1'b1; ifa.reqAddr = 32'h0000_0004;
    @(posedge CLK); #1;
    ifa.reqValid = 1'b0;
    n0 = rcyc.size();
    @(posedge CLK); #1;
    RSTn = 1'b0;
    #1;
    total++;
    if ({ifa.busy, ifa.reqReady, ifa.respValid} !== 3'b000) begin
      bad++; $display("FAIL reset_mid got busy/rdy/vld=%b want 000", {ifa.busy, ifa.reqReady, ifa.respValid});
    end
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (6) @(negedge CLK);
    total++;
    if (rcyc.size() != n0 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_abort got responses=%0d busy=%0b want 0 0", rcyc.size() - n0, ifa.busy);
    end
    fetch(32'h0000_000C, 1'b0, 32'h2008_0005);
    fetch(32'h0000_0014, 1'b0, 32'h5555_5555);
  endtask
  initial begin
    test_reset();
    test_aligned();
    test_errors();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
